color_transform_poly: RTL

- Parametrised successor of the fixed-coefficient colour-transform stage in the pixel path.
- Applies a 3x18-term cubic polynomial colour correction per pixel: R3, G3, B3, R2G, RG2, G2B, GB2, B2R, BR2, R2, G2, B2, RG, GB, BR, R, G, B.
- Coefficients are signed, runtime-loadable and double-buffered; output is rounded, offset and clamped.
- Sits between the pixel source and the write-side FIFO and honours FIFO backpressure.

---
 rtl/color_pkg.sv | 41 ++++
 rtl/color_transform_poly_if.sv | 33 +++
 rtl/color_poly_mac.sv | 32 +++
 rtl/color_transform_poly.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared constants, term ordering and clamp helper for the polynomial colour transform.
// Coefficient address = channel*NUM_TERMS + term, with the term indices below (0-based).
package color_pkg;
  localparam int NUM_TERMS = 18;
  localparam int NUM_CH    = 3;
  localparam int NUM_COEF  = NUM_CH * NUM_TERMS;

  localparam int T_R3  = 0,  T_G3  = 1,  T_B3  = 2;
  localparam int T_R2G = 3,  T_RG2 = 4,  T_G2B = 5;
  localparam int T_GB2 = 6,  T_B2R = 7,  T_BR2 = 8;
  localparam int T_R2  = 9,  T_G2  = 10, T_B2  = 11;
  localparam int T_RG  = 12, T_GB  = 13, T_BR  = 14;
  localparam int T_R   = 15, T_G   = 16, T_B   = 17;

  // Bits set where the identity bank holds 1.0: R->ch0, G->ch1, B->ch2.
  localparam logic [NUM_COEF-1:0] IDENT_MASK =
      (NUM_COEF'(1) << T_R) |
      (NUM_COEF'(1) << (NUM_TERMS + T_G)) |
      (NUM_COEF'(1) << (2*NUM_TERMS + T_B));

  typedef struct packed {
    logic        clip;
    logic [31:0] val;
  } clamp_t;

  function automatic clamp_t clamp_u(input logic signed [63:0] v, input int pix_w);
    clamp_t r;
    logic signed [63:0] maxv;
    maxv   = (64'sd1 <<< pix_w) - 64'sd1;
    r.clip = 1'b0;
    r.val  = v[31:0];
    if (v < 0) begin
      r.clip = 1'b1;
      r.val  = '0;
    end else if (v > maxv) begin
      r.clip = 1'b1;
      r.val  = maxv[31:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/color_transform_poly_if.sv
// Pixel in/out, coefficient load and clip-counter signals of the colour transform.
interface color_transform_poly_if #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 10,
  parameter int COEF_W  = 20
);
  logic                      valid, ready;
  logic [COORD_W-1:0]        x_i, y_i;
  logic [PIX_W-1:0]          red_i, green_i, blue_i;
  logic signed [PIX_W:0]     r_shift_i, g_shift_i, b_shift_i;
  logic                      bypass;
  logic                      coef_we;
  logic [5:0]                coef_addr;
  logic [COEF_W-1:0]         coef_wdata;
  logic                      coef_commit, commit_pending;
  logic                      wrfull, wrreq;
  logic [COORD_W-1:0]        x_o, y_o;
  logic [PIX_W-1:0]          red_o, green_o, blue_o;
  logic [15:0]               clip_cnt;
  logic                      clip_clr;

  modport master (
    output valid, x_i, y_i, red_i, green_i, blue_i, r_shift_i, g_shift_i, b_shift_i, bypass,
           coef_we, coef_addr, coef_wdata, coef_commit, wrfull, clip_clr,
    input  ready, commit_pending, wrreq, x_o, y_o, red_o, green_o, blue_o, clip_cnt
  );

  modport slave (
    input  valid, x_i, y_i, red_i, green_i, blue_i, r_shift_i, g_shift_i, b_shift_i, bypass,
           coef_we, coef_addr, coef_wdata, coef_commit, wrfull, clip_clr,
    output ready, commit_pending, wrreq, x_o, y_o, red_o, green_o, blue_o, clip_cnt
  );
endinterface

// File: rtl/color_poly_mac.sv
// One channel of stage 2: signed sum of NUM_TERMS coefficient*monomial products, registered.
module color_poly_mac
  import color_pkg::*;
#(
  parameter int MON_W  = 24,
  parameter int COEF_W = 20,
  parameter int ACC_W  = 50
) (
  input  logic                                 clk_25,
  input  logic                                 reset,
  input  logic                                 i_en,
  input  logic [NUM_TERMS-1:0][MON_W-1:0]      i_mon,
  input  logic [NUM_TERMS-1:0][COEF_W-1:0]     i_coef,
  output logic [ACC_W-1:0]                     o_acc
);
  logic signed [ACC_W-1:0] w_sum;
  logic        [ACC_W-1:0] r_acc;

  // Monomials are unsigned; a zero MSB keeps them positive in the signed product.
  always_comb begin
    w_sum = '0;
    for (int t = 0; t < NUM_TERMS; t++)
      w_sum = w_sum + ACC_W'($signed(i_coef[t])) * ACC_W'($signed({1'b0, i_mon[t]}));
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset)    r_acc <= '0;
    else if (i_en) r_acc <= w_sum;
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/color_transform_poly.sv
// Cubic polynomial colour correction with double-buffered signed coefficients, 3-stage
// pipeline stalled by downstream FIFO full; output rounded, offset and clamped.
module color_transform_poly
  import color_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int COORD_W   = 10,
  parameter int COEF_W    = 20,
  parameter int FRAC_BITS = 16,
  parameter int ACC_W     = 3*PIX_W + COEF_W + 6
) (
  input  logic                   clk_25,
  input  logic                   reset,
  color_transform_poly_if.slave  bus
);
  localparam int MON_W = 3*PIX_W;
  localparam int SUM_W = ACC_W + 2;
  localparam logic [COEF_W-1:0]       COEF_ONE = COEF_W'(1) << FRAC_BITS;
  localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(1) <<< (FRAC_BITS-1);

  logic w_adv, w_acc, w_copy, r_pend;
  logic [3:1] r_vld_pipe;

  logic [NUM_CH-1:0][NUM_TERMS-1:0][COEF_W-1:0] r_shadow, r_active;

  logic [NUM_CH-1:0][PIX_W-1:0] w_rgb_in, r_rgb1, r_rgb2, w_pix3, r_pix3;
  logic [NUM_CH-1:0][PIX_W:0]   w_shf_in, r_shf1, r_shf2;
  logic [NUM_CH-1:0][ACC_W-1:0] w_acc2;
  logic [NUM_CH-1:0]            w_clip3, r_clip3;
  logic [COORD_W-1:0]           r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
  logic                         r_byp1, r_byp2;

  logic [MON_W-1:0]                  w_r, w_g, w_b;
  logic [NUM_TERMS-1:0][MON_W-1:0]   w_mon, r_mon1;
  logic [15:0]                       r_clip_cnt;
  logic [1:0]                        w_ninc;
  logic [16:0]                       w_cnt_sum;

  // Only a full output register facing a full FIFO can stall the pipe.
  assign w_adv     = !(r_vld_pipe[3] && bus.wrfull);
  assign bus.ready = w_adv;
  assign w_acc     = bus.valid && w_adv;
  assign bus.wrreq = r_vld_pipe[3] && !bus.wrfull;

  // Swap banks at frame start (pixel 0,0 accepted) or whenever the pipe is empty and idle.
  assign w_copy = r_pend && ((w_acc && bus.x_i == '0 && bus.y_i == '0) ||
                             (r_vld_pipe == '0 && !w_acc));
  assign bus.commit_pending = r_pend;

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      r_pend <= 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        for (int t = 0; t < NUM_TERMS; t++) begin
          r_shadow[c][t] <= IDENT_MASK[c*NUM_TERMS+t] ? COEF_ONE : '0;
          r_active[c][t] <= IDENT_MASK[c*NUM_TERMS+t] ? COEF_ONE : '0;
        end
    end else begin
      if (w_copy) r_active <= r_shadow;
      if (bus.coef_we)
        for (int c = 0; c < NUM_CH; c++)
          for (int t = 0; t < NUM_TERMS; t++)
            if (bus.coef_addr == 6'(c*NUM_TERMS + t)) r_shadow[c][t] <= bus.coef_wdata;
      if (bus.coef_commit) r_pend <= 1'b1;
      else if (w_copy)     r_pend <= 1'b0;
    end
  end

  // Stage 1 inputs: channel 0 = red, 1 = green, 2 = blue.
  assign w_rgb_in = {bus.blue_i, bus.green_i, bus.red_i};
  assign w_shf_in = {bus.b_shift_i, bus.g_shift_i, bus.r_shift_i};
  assign w_r = MON_W'(bus.red_i);
  assign w_g = MON_W'(bus.green_i);
  assign w_b = MON_W'(bus.blue_i);

  always_comb begin
    w_mon        = '0;
    w_mon[T_R3]  = w_r * w_r * w_r;
    w_mon[T_G3]  = w_g * w_g * w_g;
    w_mon[T_B3]  = w_b * w_b * w_b;
    w_mon[T_R2G] = w_r * w_r * w_g;
    w_mon[T_RG2] = w_r * w_g * w_g;
    w_mon[T_G2B] = w_g * w_g * w_b;
    w_mon[T_GB2] = w_g * w_b * w_b;
    w_mon[T_B2R] = w_b * w_b * w_r;
    w_mon[T_BR2] = w_b * w_r * w_r;
    w_mon[T_R2]  = w_r * w_r;
    w_mon[T_G2]  = w_g * w_g;
    w_mon[T_B2]  = w_b * w_b;
    w_mon[T_RG]  = w_r * w_g;
    w_mon[T_GB]  = w_g * w_b;
    w_mon[T_BR]  = w_b * w_r;
    w_mon[T_R]   = w_r;
    w_mon[T_G]   = w_g;
    w_mon[T_B]   = w_b;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [SUM_W-1:0] w_scl, w_sum;
    clamp_t                  w_cl;
    logic                    w_unused_hi;

    color_poly_mac #(.MON_W(MON_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
      .clk_25 (clk_25),
      .reset  (reset),
      .i_en   (w_adv),
      .i_mon  (r_mon1),
      .i_coef (r_active[c]),
      .o_acc  (w_acc2[c])
    );

    always_comb begin
      w_scl = (SUM_W'($signed(w_acc2[c])) + RND_HALF) >>> FRAC_BITS;
      w_sum = w_scl + SUM_W'($signed(r_shf2[c]));
      w_cl  = clamp_u(64'(w_sum), PIX_W);
    end

    assign w_unused_hi = |w_cl.val[31:PIX_W];
    assign w_pix3[c]   = r_byp2 ? r_rgb2[c] : w_cl.val[PIX_W-1:0];
    assign w_clip3[c]  = !r_byp2 && w_cl.clip;
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_x1 <= '0; r_y1 <= '0; r_byp1 <= 1'b0; r_rgb1 <= '0; r_shf1 <= '0; r_mon1 <= '0;
      r_x2 <= '0; r_y2 <= '0; r_byp2 <= 1'b0; r_rgb2 <= '0; r_shf2 <= '0;
      r_x3 <= '0; r_y3 <= '0; r_pix3 <= '0; r_clip3 <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[2:1], bus.valid};
      r_x1 <= bus.x_i; r_y1 <= bus.y_i; r_byp1 <= bus.bypass;
      r_rgb1 <= w_rgb_in; r_shf1 <= w_shf_in; r_mon1 <= w_mon;
      r_x2 <= r_x1; r_y2 <= r_y1; r_byp2 <= r_byp1; r_rgb2 <= r_rgb1; r_shf2 <= r_shf1;
      r_x3 <= r_x2; r_y3 <= r_y2; r_pix3 <= w_pix3; r_clip3 <= w_clip3;
    end
  end

  assign bus.x_o     = r_x3;
  assign bus.y_o     = r_y3;
  assign bus.red_o   = r_pix3[0];
  assign bus.green_o = r_pix3[1];
  assign bus.blue_o  = r_pix3[2];

  assign w_ninc    = 2'(r_clip3[0]) + 2'(r_clip3[1]) + 2'(r_clip3[2]);
  assign w_cnt_sum = {1'b0, r_clip_cnt} + 17'(w_ninc);

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset)            r_clip_cnt <= '0;
    else if (bus.clip_clr) r_clip_cnt <= '0;
    else if (bus.wrreq)    r_clip_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
  end

  assign bus.clip_cnt = r_clip_cnt;
endmodule
